// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store.
// Data wins contention until a bounded streak forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  logic [1:0] r_owner;
  logic [1:0] w_owner_nxt;
  logic [3:0] r_streak;
  logic [3:0] w_streak_nxt;
  logic       w_if_gnt;
  logic       w_d_gnt;

  // Grants are masked by rst_n so nothing is accepted during reset
  always_comb begin
    w_d_gnt  = rst_n & d_req
             & (~if_req | (r_streak < STREAK_MAX));
    w_if_gnt = rst_n & if_req & ~w_d_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= OWN_NONE;
      r_streak <= 4'd0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_comb begin
    w_streak_nxt = r_streak;
    unique case (1'b1)
      (!if_req || w_if_gnt):
        w_streak_nxt = 4'd0;
      (if_req && w_d_gnt && r_streak < STREAK_MAX):
        w_streak_nxt = r_streak + 4'd1;
      default: ;
    endcase
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    unique case (1'b1)
      w_if_gnt:            w_owner_nxt = OWN_IF;
      (w_d_gnt && !d_we):  w_owner_nxt = OWN_D;
      default: ;
    endcase
  end

  always_comb begin
    if_gnt    = w_if_gnt;
    d_gnt     = w_d_gnt;
    mem_req   = w_if_gnt | w_d_gnt;
    mem_we    = w_d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_if_gnt) begin
      mem_addr  = if_addr;
    end
    if_rvalid = (r_owner == OWN_IF);
    d_rvalid  = (r_owner == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
// Inputs change at negedge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [256];

  int n_cmp;
  int n_err;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da,
                       input logic [31:0] dd);
    @(negedge clk);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".if_gnt"}, 32'(if_gnt), 0);
    chk({tag, ".d_gnt"}, 32'(d_gnt), 0);
    chk({tag, ".if_rv"}, 32'(if_rvalid), 0);
    chk({tag, ".d_rv"}, 32'(d_rvalid), 0);
    chk({tag, ".if_rd"}, if_rdata, 0);
    chk({tag, ".d_rd"}, d_rdata, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem_rdata = '0;
    rst_n   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0020;
    d_wdata = 32'h1234_5678;

    // reset with requests pending
    #2;
    chk_quiet("rst");
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;

    // 1: fetch only
    drive(1, 32'h00, 0, 0, 0, 0);
    chk("s1a.if_gnt", 32'(if_gnt), 1);
    chk("s1a.mem_addr", mem_addr, 32'h00);
    chk("s1a.if_rv", 32'(if_rvalid), 0);
    drive(1, 32'h04, 0, 0, 0, 0);
    chk("s1b.if_gnt", 32'(if_gnt), 1);
    chk("s1b.mem_addr", mem_addr, 32'h04);
    chk("s1b.if_rv", 32'(if_rvalid), 1);
    chk("s1b.if_rd", if_rdata, 32'hA000_0000);
    drive(0, 0, 0, 0, 0, 0);
    chk("s1c.if_rv", 32'(if_rvalid), 1);
    chk("s1c.if_rd", if_rdata, 32'hA000_0001);
    chk("s1c.mem_req", 32'(mem_req), 0);

    // 2: contention, data read
    drive(1, 32'h10, 1, 0, 32'h100, 0);
    chk("s2a.d_gnt", 32'(d_gnt), 1);
    chk("s2a.if_gnt", 32'(if_gnt), 0);
    chk("s2a.mem_addr", mem_addr, 32'h100);
    chk("s2a.mem_we", 32'(mem_we), 0);
    drive(1, 32'h10, 0, 0, 0, 0);
    chk("s2b.d_rv", 32'(d_rvalid), 1);
    chk("s2b.d_rd", d_rdata, 32'hA000_0040);
    chk("s2b.if_rv", 32'(if_rvalid), 0);
    chk("s2b.if_rd", if_rdata, 0);
    chk("s2b.if_gnt", 32'(if_gnt), 1);
    chk("s2b.mem_addr", mem_addr, 32'h10);
    drive(0, 0, 0, 0, 0, 0);
    chk("s2c.if_rv", 32'(if_rvalid), 1);
    chk("s2c.if_rd", if_rdata, 32'hA000_0004);
    chk("s2c.d_rv", 32'(d_rvalid), 0);

    // 3: data write then read back
    drive(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF);
    chk("s3a.d_gnt", 32'(d_gnt), 1);
    chk("s3a.mem_req", 32'(mem_req), 1);
    chk("s3a.mem_we", 32'(mem_we), 1);
    chk("s3a.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s3a.mem_addr", mem_addr, 32'h200);
    drive(0, 0, 1, 0, 32'h200, 0);
    chk("s3b.d_rv", 32'(d_rvalid), 0);
    chk("s3b.d_gnt", 32'(d_gnt), 1);
    chk("s3b.mem_we", 32'(mem_we), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("s3c.d_rv", 32'(d_rvalid), 1);
    chk("s3c.d_rd", d_rdata, 32'hDEAD_BEEF);

    // 4: starvation bound, expect D,D,D,D,IF repeating
    for (int i = 0; i < 11; i++) begin
      logic e_if;
      logic e_drv;
      logic e_irv;
      e_if  = (i % 5) == 4;
      e_drv = (i > 0) && ((i - 1) % 5 != 4);
      e_irv = (i > 0) && ((i - 1) % 5 == 4);
      drive(1, 32'h20, 1, 0, 32'h40, 0);
      chk($sformatf("s4[%0d].if_gnt", i), 32'(if_gnt), 32'(e_if));
      chk($sformatf("s4[%0d].d_gnt", i), 32'(d_gnt), 32'(!e_if));
      chk($sformatf("s4[%0d].d_rd", i), d_rdata,
          e_drv ? 32'hA000_0010 : 32'h0);
      chk($sformatf("s4[%0d].if_rd", i), if_rdata,
          e_irv ? 32'hA000_0008 : 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0);

    // 5: reset mid-read
    drive(1, 32'h08, 0, 0, 0, 0);
    chk("s5a.if_gnt", 32'(if_gnt), 1);
    chk("s5a.mem_addr", mem_addr, 32'h08);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("s5b");
    @(negedge clk);
    #1;
    chk_quiet("s5c");
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("s5d.if_rv", 32'(if_rvalid), 0);
    drive(1, 32'h00, 0, 0, 0, 0);
    chk("s5e.if_gnt", 32'(if_gnt), 1);
    chk("s5e.if_rv", 32'(if_rvalid), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("s5f.if_rv", 32'(if_rvalid), 1);
    chk("s5f.if_rd", if_rdata, 32'hA000_0000);

    // 6: idle
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk_quiet($sformatf("s6[%0d]", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous memory port between the core's instruction-fetch path and its load/store path. Each cycle it selects one requester, drives the memory port, and routes the one-cycle-later read data back to the owner. Data accesses take priority, with a bounded-streak rule so fetch is never starved. It sits between `core` and the unified memory inside `top`.

## Interface

**Parameters**
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_D_STREAK`, 4: consecutive contended data grants before fetch is forced a grant. Legal range 1..15.

**Ports**
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `if_req`  in  1: fetch request. Held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  ADDR_W: fetch address.
- `if_gnt`  out  1: fetch accepted this cycle.
- `if_rvalid`  out  1: fetch data valid.
- `if_rdata`  out  DATA_W: fetch data.
- `d_req`  in  1: data request. Held with `d_we`, `d_addr` and `d_wdata` stable until `d_gnt`.
- `d_we`  in  1: 1 means write, 0 means read.
- `d_addr`  in  ADDR_W: data address.
- `d_wdata`  in  DATA_W: write data.
- `d_gnt`  out  1: data access accepted this cycle.
- `d_rvalid`  out  1: load data valid.
- `d_rdata`  out  DATA_W: load data.
- `mem_req`  out  1: memory access strobe.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: read data, valid the cycle after a read `mem_req`.

## Operation

**Registered state**
- `owner`: 2-bit, values NONE, IF or D. It records who owns the read response due next cycle.
- `streak`: 4-bit counter.

**Selection (combinational, every cycle)**
- Only `d_req`: grant D.
- Only `if_req`: grant IF.
- Both requests and `streak` < `MAX_D_STREAK`: grant D.
- Both requests and `streak` == `MAX_D_STREAK`: grant IF.
- Neither: no grant. `mem_req`=0, and `mem_we`/`mem_addr`/`mem_wdata` = 0.

**Memory port**
- `mem_req` = (`if_gnt` | `d_gnt`).
- `mem_we` = `d_gnt` & `d_we`.
- `mem_addr` and `mem_wdata` are muxed from the granted requester. `mem_wdata` = 0 when IF is granted.

**Streak counter**
- Increments on a D grant while `if_req`=1.
- Clears on an IF grant, or in any cycle with `if_req`=0.
- Saturates at `MAX_D_STREAK`.

**Owner register (next state)**
- IF on an IF grant.
- D on a D grant with `d_we`=0.
- NONE otherwise, which covers writes and idle cycles.

**Response routing**
- `if_rvalid` = (`owner`==IF).
- `d_rvalid` = (`owner`==D).
- Each rdata output equals `mem_rdata` when its rvalid is high, and 0 otherwise.
- Writes produce no rvalid. Completion is signalled by `d_gnt` alone.

**Grant rules**
- At most one grant per cycle.
- A grant is never issued while `rst_n`=0.

## Timing

**Reset (asynchronous, while `rst_n`=0)**
- `owner`=NONE and `streak`=0.
- All outputs are 0: gnts, rvalids, rdatas, and all `mem_*` signals.

**Latency**
- Grant is issued in the same cycle as the request, so zero-cycle arbitration.
- Read data arrives exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. Throughput is one access per cycle.

**Simultaneous events**
- A response for the previous grant and a new grant can occur in the same cycle. Both are handled independently: `owner` is updated from the new grant while rvalid follows the old `owner`.

**Reset mid-read**
- Asserting `rst_n` low in the cycle after a read grant clears `owner`. The pending rvalid is dropped and never reappears after release.

**Requests deasserted before grant**
- Requests are required to hold until granted, so this is illegal.
- The arbiter still behaves combinationally: no grant and no state corruption.

## Test plan

1. **Fetch only.**
   - Stimulus: `if_req`=1, `if_addr`=0x00, then 0x04 on consecutive cycles.
   - Response: `if_gnt`=1 each cycle and `mem_addr` follows. `if_rvalid`=1 one cycle later with `if_rdata`=memory[0x00], then memory[0x04].
2. **Contention, data read.**
   - Stimulus: `if_req`=1 at 0x10, `d_req`=1 with `d_we`=0 at 0x100.
   - Response: `d_gnt`=1, `if_gnt`=0, `mem_addr`=0x100. Next cycle `d_rvalid`=1 with `d_rdata`=memory[0x100] and `if_rvalid`=0. In that same cycle, with `d_req`=0, `if_gnt`=1.
3. **Data write.**
   - Stimulus: `d_req`=1, `d_we`=1, `d_addr`=0x200, `d_wdata`=0xDEADBEEF.
   - Response: `mem_we`=1, `mem_wdata`=0xDEADBEEF, `d_gnt`=1, and no `d_rvalid` the next cycle. A following read of 0x200 returns 0xDEADBEEF.
4. **Starvation bound.**
   - Stimulus: `if_req` and `d_req` held high continuously, `MAX_D_STREAK`=4.
   - Response: the grant sequence repeats D,D,D,D,IF, and `streak` returns to 0 after each IF grant.
5. **Reset mid-read.**
   - Stimulus: IF read granted at 0x08, then `rst_n`=0 asynchronously before the next clock edge.
   - Response: `if_rvalid` stays 0, and all outputs are 0 during reset. After release, the first fetch behaves as in scenario 1.
6. **Idle.**
   - Stimulus: no requests for 5 cycles.
   - Response: `mem_req`=0 and all gnt/rvalid/rdata = 0 throughout.
